// File: rtl/stacker_btn_pkg.sv
// Shared types and default 50 MHz timing for the stacker button event path.
package stacker_btn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HELD  = 2'd2,
        LOCK  = 2'd3
    } btn_state_t;

    localparam int unsigned HOLD_CYCLES_DEF   = 25_000_000;
    localparam int unsigned REPEAT_CYCLES_DEF = 5_000_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_tick_counter.sv
// Saturating tick counter with sync clear and a programmable terminal-count flag.
module btn_tick_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_tc_c
);

    logic [CNT_W-1:0] r_count;

    // Stops at the terminal count rather than wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != i_term)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_tc_c = (r_count == i_term);

endmodule

// File: rtl/button_event.sv
// Converts the debounced button level into press/release/long/repeat pulses.
// Auto-repeat in HELD is built only when BTN_AUTOREPEAT_EN is defined.
module button_event
    import stacker_btn_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic m_clock,
    input  logic m_reset_n,
    input  logic m_state,
    input  logic m_enable,
    output logic m_press,
    output logic m_release,
    output logic m_long,
    output logic m_repeat,
    output logic m_held
);

    localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES));

    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic             r_press;
    logic             r_release;
    logic             r_long;
    logic             r_repeat;
    logic             r_held;
    logic             w_press;
    logic             w_release;
    logic             w_long;
    logic             w_repeat;
    logic             w_rpt_clr;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_tc;
    logic [CNT_W-1:0] w_term;

    btn_tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick (
        .i_clk   (m_clock),
        .i_rst_n (m_reset_n),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .i_term  (w_term),
        .o_tc_c  (w_tc)
    );

    // State and registered event outputs; reset lands in LOCK.
    always_ff @(posedge m_clock or negedge m_reset_n) begin
        if (!m_reset_n) begin
            r_state   <= LOCK;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_press   <= w_press;
            r_release <= w_release;
            r_long    <= w_long;
            r_repeat  <= w_repeat;
            r_held    <= (w_state_nxt == HELD);
        end
    end

    // Next state, event decode and counter control; release beats disable.
    always_comb begin
        w_state_nxt = r_state;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        w_rpt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        w_term      = CNT_W'(HOLD_CYCLES - 1);

        case (r_state)
            IDLE: begin
                if (m_state && m_enable) begin
                    w_state_nxt = PRESS;
                    w_press     = 1'b1;
                end else if (m_state) begin
                    w_state_nxt = LOCK;
                end
            end
            PRESS: begin
                w_cnt_en = 1'b1;
                if (!m_state) begin
                    w_state_nxt = IDLE;
                    w_release   = 1'b1;
                end else if (!m_enable) begin
                    w_state_nxt = LOCK;
                end else if (w_tc) begin
                    w_state_nxt = HELD;
                    w_long      = 1'b1;
                end
            end
            HELD: begin
                if (!m_state) begin
                    w_state_nxt = IDLE;
                    w_release   = 1'b1;
                end else if (!m_enable) begin
                    w_state_nxt = LOCK;
                end else begin
`ifdef BTN_AUTOREPEAT_EN
                    w_cnt_en = 1'b1;
                    w_term   = CNT_W'(REPEAT_CYCLES - 1);
                    if (w_tc) begin
                        w_repeat  = 1'b1;
                        w_rpt_clr = 1'b1;
                    end
`else
                    w_cnt_en = 1'b0;
`endif
                end
            end
            LOCK: begin
                if (!m_state) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = LOCK;
        endcase

        w_cnt_clr = w_rpt_clr || (w_state_nxt != r_state);
    end

    assign m_press   = r_press;
    assign m_release = r_release;
    assign m_long    = r_long;
    assign m_repeat  = r_repeat;
    assign m_held    = r_held;

endmodule

// File: tb/tb_button_event.sv
// Directed and randomized bench for button_event against a timing-based reference model.
module tb_button_event;

    localparam int unsigned HOLD   = 8;
    localparam int unsigned REPEAT = 4;

    logic m_clock   = 1'b0;
    logic m_reset_n = 1'b0;
    logic m_state   = 1'b1;
    logic m_enable  = 1'b1;
    logic m_press, m_release, m_long, m_repeat, m_held;

    int checks = 0;
    int errors = 0;

    // Reference model: accepted-press bookkeeping in terms of elapsed edges.
    bit locked  = 1'b1;
    bit pressed = 1'b0;
    bit long_done = 1'b0;
    int age     = 0;
    int rpt_age = 0;
    bit e_press, e_release, e_long, e_repeat, e_held;

    button_event #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REPEAT)
    ) dut (
        .m_clock   (m_clock),
        .m_reset_n (m_reset_n),
        .m_state   (m_state),
        .m_enable  (m_enable),
        .m_press   (m_press),
        .m_release (m_release),
        .m_long    (m_long),
        .m_repeat  (m_repeat),
        .m_held    (m_held)
    );

    always #5 m_clock = ~m_clock;

    task automatic model_reset();
        locked = 1'b1; pressed = 1'b0; long_done = 1'b0; age = 0; rpt_age = 0;
        e_press = 0; e_release = 0; e_long = 0; e_repeat = 0; e_held = 0;
    endtask

    task automatic model_edge(input bit s, input bit en);
        e_press = 0; e_release = 0; e_long = 0; e_repeat = 0;
        if (locked) begin
            if (!s) locked = 1'b0;
        end else if (!pressed) begin
            if (s && en) begin
                pressed = 1'b1; long_done = 1'b0; age = 0; e_press = 1;
            end else if (s) begin
                locked = 1'b1;
            end
        end else begin
            if (!s) begin
                pressed = 1'b0; e_release = 1;
            end else if (!en) begin
                pressed = 1'b0; locked = 1'b1;
            end else begin
                age++;
                if (!long_done && age == int'(HOLD)) begin
                    long_done = 1'b1; rpt_age = 0; e_long = 1;
                end else if (long_done) begin
                    rpt_age++;
`ifdef BTN_AUTOREPEAT_EN
                    if (rpt_age % int'(REPEAT) == 0) e_repeat = 1;
`endif
                end
            end
        end
        e_held = pressed && long_done;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_bit("press",   m_press,   e_press);
        check_bit("release", m_release, e_release);
        check_bit("long",    m_long,    e_long);
        check_bit("repeat",  m_repeat,  e_repeat);
        check_bit("held",    m_held,    e_held);
    endtask

    task automatic step(input logic s, input logic en);
        @(negedge m_clock);
        m_state  = s;
        m_enable = en;
        @(posedge m_clock);
        model_edge(s, en);
        #1;
        check_all();
    endtask

    task automatic hold(input logic s, input logic en, input int n);
        for (int i = 0; i < n; i++) step(s, en);
    endtask

    initial begin
        model_reset();
        // Reset state with the button held through reset.
        repeat (3) @(posedge m_clock);
        #1;
        check_all();
        @(negedge m_clock);
        m_reset_n = 1'b1;

        // Lock after reset: held 20 cycles, then release, then re-press.
        hold(1, 1, 20);
        hold(0, 1, 2);
        hold(1, 1, 1);
        hold(0, 1, 3);

        // Short tap.
        hold(1, 1, 3);
        hold(0, 1, 4);

        // Long hold with long-press and optional repeats.
        hold(1, 1, 20);
        hold(0, 1, 3);

        // Disable in PRESS, re-enable while held, then release and re-press.
        hold(1, 1, 3);
        hold(1, 0, 2);
        hold(1, 1, 12);
        hold(0, 1, 2);
        hold(1, 1, 2);
        hold(0, 1, 2);

        // Simultaneous release and disable in HELD.
        hold(1, 1, 10);
        hold(0, 0, 2);
        hold(0, 1, 2);

        // Async reset mid-HELD.
        hold(1, 1, 11);
        #2;
        m_reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge m_clock);
        m_reset_n = 1'b1;
        hold(1, 1, 6);
        hold(0, 1, 1);
        hold(1, 1, 2);
        hold(0, 1, 2);

        // Randomized bursts of levels and enable.
        for (int b = 0; b < 60; b++) begin
            logic s;
            int   len;
            s   = logic'($urandom_range(0, 1));
            len = int'($urandom_range(1, 22));
            for (int i = 0; i < len; i++) begin
                step(s, logic'($urandom_range(0, 11) != 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
